// File: rtl/ps2_scancode_tracker.sv
// ps2_scancode_tracker: decodes PS/2 set-2 make/break/E0 byte sequences into key events
// and tracks the held state of the forward/backward keys to drive the accel command.
module ps2_scancode_tracker #(
  parameter logic [7:0] KEY_FWD   = 8'h73,
  parameter logic [7:0] KEY_BWD   = 8'h72,
  parameter bit         MATCH_EXT = 1'b0,
  parameter int         PREFIX_TO = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [1:0] accel,
  output logic       fwd_held,
  output logic       bwd_held,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_break,
  output logic       proto_error
);
  localparam int CW = $clog2(PREFIX_TO + 1);
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] code_q, code_d;
  logic [1:0] accel_q, accel_d;
  logic valid_q, valid_d, ext_q, ext_d, brk_q, brk_d, err_q, err_d;
  logic fwd_q, fwd_d, bwd_q, bwd_d, expire;
  logic [7:0] b;
  assign b = received_data;
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    code_d  = code_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    err_d   = 1'b0;
    fwd_d   = fwd_q;
    bwd_d   = bwd_q;
    expire  = (state_q != IDLE) && (cnt_q == CW'(PREFIX_TO - 1));
    cnt_d   = (received_data_en || state_q == IDLE || expire) ? '0 : cnt_q + CW'(1);
    if (received_data_en) begin
      case (state_q)
        IDLE:
          if (b == 8'hE0) state_d = GOT_E0;
          else if (b == 8'hF0) state_d = GOT_F0;
          else if (b == 8'hAA) begin
            fwd_d = 1'b0;
            bwd_d = 1'b0;
          end else if (!(b inside {8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            valid_d = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        GOT_E0:
          if (b == 8'hF0) state_d = GOT_E0F0;
          else if (b != 8'hE0) begin
            valid_d = 1'b1;
            ext_d   = 1'b1;
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        default: begin
          state_d = IDLE;
          if (b == 8'hE0 || b == 8'hF0) err_d = 1'b1;
          else begin
            valid_d = 1'b1;
            ext_d   = (state_q == GOT_E0F0);
            brk_d   = 1'b1;
          end
        end
      endcase
      if (valid_d) code_d = b;
    end else if (expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    // held flags and accel see this cycle's event so all outputs move together at N+1
    if (valid_d && code_d == KEY_FWD && ext_d == MATCH_EXT) fwd_d = ~brk_d;
    if (valid_d && code_d == KEY_BWD && ext_d == MATCH_EXT) bwd_d = ~brk_d;
    accel_d = {fwd_d & ~bwd_d, bwd_d & ~fwd_d};
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      err_q   <= 1'b0;
      fwd_q   <= 1'b0;
      bwd_q   <= 1'b0;
      accel_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
      fwd_q   <= fwd_d;
      bwd_q   <= bwd_d;
      accel_q <= accel_d;
    end
  end
  assign accel       = accel_q;
  assign fwd_held    = fwd_q;
  assign bwd_held    = bwd_q;
  assign event_valid = valid_q;
  assign event_code  = code_q;
  assign event_ext   = ext_q;
  assign event_break = brk_q;
  assign proto_error = err_q;
endmodule
